// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the read-side output-stage state type.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int PTR_W  = ADDR_W + 1;

    // IDLE: output register empty; LOADED: output register holds a word.
    typedef enum logic {
        IDLE   = 1'b0,
        LOADED = 1'b1
    } out_state_e;

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side FIFO bus: pointer exchange, memory read data, FWFT output and status.
interface fifo_read_ctrl_if #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int ADDR_W = fifo_pkg::ADDR_W
);

    logic [ADDR_W:0]   wptr;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W:0]   rptr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              fifo_empty;
    logic [ADDR_W+1:0] fifo_level;
    logic              almost_empty;
    logic              pop_err;
    logic              pop_err_clr;

    // Read controller side.
    modport master (
        input  wptr, mem_data, dout_ready, pop_err_clr,
        output rptr, dout, dout_valid, fifo_empty, fifo_level, almost_empty, pop_err
    );

    // Surrounding FIFO / consumer side.
    modport slave (
        output wptr, mem_data, dout_ready, pop_err_clr,
        input  rptr, dout, dout_valid, fifo_empty, fifo_level, almost_empty, pop_err
    );

endinterface

// File: rtl/fifo_read_ctrl.sv
// FIFO read controller: first-word-fall-through output register fed from an
// asynchronous-read memory, read pointer management and occupancy status.
module fifo_read_ctrl #(
    parameter int DATA_W   = fifo_pkg::DATA_W,
    parameter int ADDR_W   = fifo_pkg::ADDR_W,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    fifo_read_ctrl_if.master bus
);

    import fifo_pkg::*;

    localparam int RP_W = ADDR_W + 1;
    localparam int LV_W = ADDR_W + 2;
    localparam logic [LV_W-1:0] AE_THR = LV_W'(AE_LEVEL);

    out_state_e        r_state;
    logic [RP_W-1:0]   r_rptr;
    logic [DATA_W-1:0] r_dout;
    logic              r_pop_err;

    logic              w_valid;
    logic              w_empty;
    logic [RP_W-1:0]   w_diff;
    logic [LV_W-1:0]   w_level;
    logic [RP_W-1:0]   w_rptr_inc;

    // Occupancy: unread memory words plus the staged output word.
    always_comb begin
        w_valid    = (r_state == LOADED);
        w_empty    = (bus.wptr == r_rptr);
        w_diff     = bus.wptr - r_rptr;
        w_level    = {1'b0, w_diff} + {{(LV_W-1){1'b0}}, w_valid};
        w_rptr_inc = r_rptr + {{(RP_W-1){1'b0}}, 1'b1};
    end

    // Output-stage FSM: load the head word whenever the register is empty or being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rptr  <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_dout  <= bus.mem_data;
                        r_rptr  <= w_rptr_inc;
                        r_state <= LOADED;
                    end
                end
                LOADED: begin
                    if (bus.dout_ready) begin
                        if (!w_empty) begin
                            r_dout <= bus.mem_data;
                            r_rptr <= w_rptr_inc;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Sticky underflow flag; a new violation takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop_err <= 1'b0;
        end else if (bus.dout_ready && !w_valid) begin
            r_pop_err <= 1'b1;
        end else if (bus.pop_err_clr) begin
            r_pop_err <= 1'b0;
        end
    end

    assign bus.rptr         = r_rptr;
    assign bus.dout         = r_dout;
    assign bus.dout_valid   = w_valid;
    assign bus.fifo_empty   = w_empty;
    assign bus.fifo_level   = w_level;
    assign bus.almost_empty = (w_level <= AE_THR);
    assign bus.pop_err      = r_pop_err;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: memory and write controller are modelled here,
// expected behaviour comes from a queue-based model of the FIFO contents.
module tb_fifo_read_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_read_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    logic [DW-1:0] mem [16];
    logic [AW:0]   wp;

    assign bus.wptr     = wp;
    assign bus.mem_data = mem[bus.rptr[AW-1:0]];

    fifo_read_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AE_LEVEL(AE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: words in memory not yet taken, staged word, reads done, sticky flag.
    logic [7:0]  mq[$];
    bit          m_valid;
    logic [7:0]  m_dout;
    int unsigned m_reads;
    bit          m_perr;
    bit          rst_seen;

    logic [7:0]  got[$];
    bit          rec;
    logic [4:0]  prev_rp;
    bit          saw16;
    bit          saw0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wp[AW-1:0]] = d;
        wp = wp + 5'd1;
        mq.push_back(d);
    endtask

    task automatic model_edge();
        bit ready;
        bit clr;
        ready    = bus.dout_ready;
        clr      = bus.pop_err_clr;
        rst_seen = rst;
        if (rst) begin
            mq.delete();
            m_valid = 0;
            m_dout  = '0;
            m_reads = 0;
            m_perr  = 0;
        end else begin
            if (ready && !m_valid) m_perr = 1;
            else if (clr)          m_perr = 0;
            if (!m_valid || ready) begin
                if (mq.size() > 0) begin
                    m_dout  = mq.pop_front();
                    m_valid = 1;
                    m_reads++;
                end else begin
                    m_valid = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        int unsigned lvl;
        lvl = mq.size() + (m_valid ? 1 : 0);
        chk("rptr",         32'(bus.rptr),         32'(m_reads % 32));
        chk("dout",         32'(bus.dout),         32'(m_dout));
        chk("dout_valid",   32'(bus.dout_valid),   32'(m_valid));
        chk("fifo_empty",   32'(bus.fifo_empty),   32'(mq.size() == 0));
        chk("fifo_level",   32'(bus.fifo_level),   32'(lvl));
        chk("almost_empty", 32'(bus.almost_empty), 32'(lvl <= AE));
        chk("pop_err",      32'(bus.pop_err),      32'(m_perr));
    endtask

    task automatic step();
        if (rec && bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
        @(posedge clk);
        model_edge();
        #1;
        if (rst_seen) wp = '0;
        #1;
        check_all();
        if (prev_rp == 5'd15 && bus.rptr == 5'd16) saw16 = 1;
        if (prev_rp == 5'd31 && bus.rptr == 5'd0)  saw0  = 1;
        prev_rp = bus.rptr;
    endtask

    initial begin
        rst             = 1'b1;
        wp              = '0;
        bus.dout_ready  = 1'b0;
        bus.pop_err_clr = 1'b0;
        rec             = 0;
        prev_rp         = '0;
        saw16           = 0;
        saw0            = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        step();
        step();
        rst = 1'b0;

        // Single word 0xA5
        write_word(8'hA5);
        step();
        chk("a5_valid", 32'(bus.dout_valid), 32'd1);
        chk("a5_dout",  32'(bus.dout),       32'hA5);
        chk("a5_rptr",  32'(bus.rptr),       32'd1);
        chk("a5_level", 32'(bus.fifo_level), 32'd1);
        chk("a5_empty", 32'(bus.fifo_empty), 32'd1);

        // Fill: 16 in memory plus one staged
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            write_word(8'(i));
            step();
        end
        chk("full_level", 32'(bus.fifo_level),   32'd17);
        chk("full_dout",  32'(bus.dout),         32'h00);
        chk("full_rptr",  32'(bus.rptr),         32'd2);
        chk("full_ae",    32'(bus.almost_empty), 32'd0);

        // Drain back-to-back
        bus.dout_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("drain_dout", 32'(bus.dout), 32'(i));
        end
        step();
        bus.dout_ready = 1'b0;
        chk("drain_end_valid", 32'(bus.dout_valid), 32'd0);
        chk("drain_end_hold",  32'(bus.dout),       32'h10);

        // Streaming across both pointer wrap points
        rec = 1;
        got.delete();
        saw16 = 0;
        saw0  = 0;
        for (int i = 0; i < 40; i++) begin
            write_word(8'(8'h40 + i));
            step();
            bus.dout_ready = 1'b1;
        end
        step();
        bus.dout_ready = 1'b0;
        rec = 0;
        chk("stream_count", 32'(got.size()), 32'd40);
        for (int i = 0; i < 40; i++) begin
            chk("stream_word", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(8'h40 + i));
        end
        chk("stream_wrap16", 32'(saw16), 32'd1);
        chk("stream_wrap0",  32'(saw0),  32'd1);

        // Underflow flag behaviour
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
        chk("perr_set", 32'(bus.pop_err), 32'd1);
        step();
        chk("perr_sticky", 32'(bus.pop_err), 32'd1);
        bus.dout_ready  = 1'b1;
        bus.pop_err_clr = 1'b1;
        step();
        chk("perr_set_wins", 32'(bus.pop_err), 32'd1);
        bus.dout_ready = 1'b0;
        step();
        bus.pop_err_clr = 1'b0;
        chk("perr_clr", 32'(bus.pop_err), 32'd0);

        // Randomized traffic: drain-heavy, then fill-heavy
        for (int c = 0; c < 600; c++) begin
            if (c < 300) bus.dout_ready = ($urandom_range(0, 3) != 0);
            else         bus.dout_ready = ($urandom_range(0, 3) == 0);
            bus.pop_err_clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 99) == 0);
            if (!rst && mq.size() < 16) begin
                if ((c < 300 && $urandom_range(0, 1) == 1) || (c >= 300 && $urandom_range(0, 3) != 0))
                    write_word(8'($urandom));
            end
            step();
        end
        rst = 1'b0;

        // Mid-stream reset with 5 words in memory and one staged
        bus.pop_err_clr = 1'b0;
        bus.dout_ready  = 1'b1;
        for (int i = 0; i < 20; i++) step();
        bus.dout_ready = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            write_word(8'(8'hC0 + i));
            step();
        end
        chk("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
        chk("pre_rst_level", 32'(bus.fifo_level), 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rptr",  32'(bus.rptr),         32'd0);
        chk("rst_dout",  32'(bus.dout),         32'd0);
        chk("rst_valid", 32'(bus.dout_valid),   32'd0);
        chk("rst_level", 32'(bus.fifo_level),   32'd0);
        chk("rst_ae",    32'(bus.almost_empty), 32'd1);
        chk("rst_perr",  32'(bus.pop_err),      32'd0);
        step();
        chk("post_rst_empty", 32'(bus.fifo_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
